// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and default sizes for the PE job controller
package pe_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int PSUM_W_DEF  = 2 * DATA_W_DEF + 4;
  localparam int WSPAD_N_DEF = 16;
  localparam int ASPAD_N_DEF = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADW,
    ST_LOADA,
    ST_START,
    ST_WAIT,
    ST_SUMS
  } state_e;
endpackage

// File: rtl/pe_ld_seq.sv
// rtl/pe_ld_seq.sv - count-N stream loader: each accepted beat becomes a one-cycle strobe
// with its data registered; last_o flags the beat that completes the count.
module pe_ld_seq
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              strobe_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);
  logic [CNT_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              strobe_q;
  logic              xfer;

  assign s_ready_o = en_i;
  assign xfer      = en_i & s_valid_i;
  assign last_o    = xfer && ((cnt_q + 1'b1) == {1'b0, count_i});
  assign strobe_o  = strobe_q;
  assign data_o    = data_q;

  // The counter is cleared whenever the loader is idle, so every job restarts from zero.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d  = cnt_q + 1'b1;
      data_d = s_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= xfer;
    end
  end
endmodule

// File: rtl/pe_ctrl.sv
// rtl/pe_ctrl.sv - PE job controller: config check, weight/activation load, start,
// bounded wait for done, then N = acount+1-wcount psum read cycles.
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PSUM_W  = PSUM_W_DEF,
  parameter int WSPAD_N = WSPAD_N_DEF,
  parameter int ASPAD_N = ASPAD_N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_wcount,
  input  logic [CNT_W-1:0]  cfg_acount,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] pe_weights,
  output logic [DATA_W-1:0] pe_acts,
  output logic              pe_loadw,
  output logic              pe_loada,
  output logic              pe_start,
  output logic              pe_sums,
  output logic [CNT_W-1:0]  pe_wcount,
  output logic [CNT_W-1:0]  pe_acount,
  input  logic              pe_done,
  input  logic [PSUM_W-1:0] pe_psum_o,
  input  logic [PSUM_W-1:0] psum_seed,
  output logic [PSUM_W-1:0] pe_psum_i,
  output logic              out_valid,
  output logic [PSUM_W-1:0] out_data,
  output logic              busy,
  output logic              err_cfg,
  output logic              err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0]  W_MAX  = (CNT_W + 1)'(WSPAD_N);
  localparam logic [CNT_W:0]  A_MAX  = (CNT_W + 1)'(ASPAD_N);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcount_q, wcount_d, acount_q, acount_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [CNT_W:0]   sums_q, sums_d;
  logic             pe_start_q, pe_start_d;
  logic             err_cfg_q, err_cfg_d, err_to_q, err_to_d;
  logic             out_valid_q;
  logic             w_last, a_last, cfg_ok;
  logic [CNT_W:0]   wc_x, ac_x, n_last;

  assign wc_x   = {1'b0, cfg_wcount};
  assign ac_x   = {1'b0, cfg_acount};
  assign cfg_ok = (wc_x != '0) && (wc_x <= W_MAX) && (wc_x <= ac_x) && (ac_x <= A_MAX);
  // Index of the final sums cycle, i.e. N-1; never negative once the config is accepted.
  assign n_last = {1'b0, acount_q} - {1'b0, wcount_q};

  pe_ld_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ld_w (
    .clk(clk), .rst(rst), .en_i(state_q == ST_LOADW), .count_i(wcount_q),
    .s_valid_i(w_valid), .s_ready_o(w_ready), .s_data_i(w_data),
    .strobe_o(pe_loadw), .data_o(pe_weights), .last_o(w_last)
  );

  pe_ld_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ld_a (
    .clk(clk), .rst(rst), .en_i(state_q == ST_LOADA), .count_i(acount_q),
    .s_valid_i(a_valid), .s_ready_o(a_ready), .s_data_i(a_data),
    .strobe_o(pe_loada), .data_o(pe_acts), .last_o(a_last)
  );

  always_comb begin
    state_d    = state_q;
    wcount_d   = wcount_q;
    acount_d   = acount_q;
    wait_d     = '0;
    sums_d     = '0;
    pe_start_d = 1'b0;
    err_cfg_d  = 1'b0;
    err_to_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          wcount_d = cfg_wcount;
          acount_d = cfg_acount;
          if (cfg_ok) state_d = ST_LOADW;
          else        err_cfg_d = 1'b1;
        end
      end
      ST_LOADW: if (w_last) state_d = ST_LOADA;
      ST_LOADA: if (a_last) state_d = ST_START;
      // pe_start is registered so it lands one cycle after the final activation strobe.
      ST_START: begin
        pe_start_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (pe_done) begin
          state_d = ST_SUMS;
        end else if (wait_q == T_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SUMS: begin
        if (sums_q == n_last) state_d = ST_IDLE;
        else                  sums_d  = sums_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcount_q    <= '0;
      acount_q    <= '0;
      wait_q      <= '0;
      sums_q      <= '0;
      pe_start_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_to_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcount_q    <= wcount_d;
      acount_q    <= acount_d;
      wait_q      <= wait_d;
      sums_q      <= sums_d;
      pe_start_q  <= pe_start_d;
      err_cfg_q   <= err_cfg_d;
      err_to_q    <= err_to_d;
      out_valid_q <= pe_sums;
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign pe_sums     = (state_q == ST_SUMS);
  assign pe_start    = pe_start_q;
  assign pe_wcount   = wcount_q;
  assign pe_acount   = acount_q;
  assign pe_psum_i   = psum_seed;
  assign out_valid   = out_valid_q;
  assign out_data    = pe_psum_o;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_to_q;
endmodule

// File: tb/tb_pe_ctrl.sv
// tb/tb_pe_ctrl.sv - scoreboard bench for pe_ctrl with a behavioural PE responder
`timescale 1ns/1ps
module tb_pe_ctrl;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int PW = 20;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [CW-1:0] cfg_wcount = '0, cfg_acount = '0;
  logic          w_valid = 1'b0, w_ready;
  logic [DW-1:0] w_data = '0;
  logic          a_valid = 1'b0, a_ready;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] pe_weights, pe_acts;
  logic          pe_loadw, pe_loada, pe_start, pe_sums;
  logic [CW-1:0] pe_wcount, pe_acount;
  logic          pe_done = 1'b0;
  logic [PW-1:0] pe_psum_o = '0, psum_seed = '0, pe_psum_i, out_data;
  logic          out_valid, busy, err_cfg, err_timeout;

  pe_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_wcount(cfg_wcount), .cfg_acount(cfg_acount),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_weights(pe_weights), .pe_acts(pe_acts),
    .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
    .pe_wcount(pe_wcount), .pe_acount(pe_acount),
    .pe_done(pe_done), .pe_psum_o(pe_psum_o),
    .psum_seed(psum_seed), .pe_psum_i(pe_psum_i),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_w[$];
  logic [DW-1:0] exp_a[$];
  logic [PW-1:0] exp_out[$];
  int exp_cfg_err = 0, exp_to = 0;
  int cnt_loadw = 0, cnt_loada = 0, cnt_start = 0, cnt_sums = 0, cnt_out = 0;
  int cnt_ecfg = 0, cnt_eto = 0;
  int cyc = 0, t_start = 0;
  logic prev_loada = 1'b0;
  bit hold_low = 1'b0;
  int w_vec[16];
  int a_vec[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no matching event, expected one", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or result.
  always @(negedge clk) begin
    if (rst) begin
      prev_loada = 1'b0;
    end else begin
      if (pe_loadw) begin
        cnt_loadw++;
        if (exp_w.size() == 0) fail("pe_loadw_unexpected");
        else chk("pe_weights", pe_weights, exp_w.pop_front());
      end
      if (pe_loada) begin
        cnt_loada++;
        if (exp_a.size() == 0) fail("pe_loada_unexpected");
        else chk("pe_acts", pe_acts, exp_a.pop_front());
      end
      if (pe_loadw || pe_loada) chk("loadw_loada_exclusive", pe_loadw & pe_loada, 0);
      if (pe_start) begin
        cnt_start++;
        t_start = cyc;
        chk("start_after_last_loada", prev_loada, 1);
      end
      if (pe_sums) cnt_sums++;
      if (out_valid) begin
        cnt_out++;
        if (exp_out.size() == 0) fail("out_valid_unexpected");
        else chk("out_data", out_data, exp_out.pop_front());
      end
      if (err_cfg) begin
        cnt_ecfg++;
        chk("err_cfg_expected", exp_cfg_err > 0, 1);
        if (exp_cfg_err > 0) exp_cfg_err--;
      end
      if (err_timeout) begin
        cnt_eto++;
        chk("err_timeout_expected", exp_to > 0, 1);
        if (exp_to > 0) exp_to--;
        chk("err_timeout_cycle", cyc, t_start + TO);
        chk("err_timeout_cfg_ready", cfg_ready, 1);
      end
      prev_loada = pe_loada;
    end
    cyc++;
  end

  // PE responder: captures loaded data, raises done 4 cycles after start, and
  // returns each psum one cycle after its pe_sums cycle (garbage otherwise).
  int pw[16];
  int pa[16];
  int wi = 0, ai = 0, skc = 0, dcnt = 0;

  function automatic int pe_conv(input int k);
    int s = int'(pe_psum_i);
    for (int j = 0; j < wi; j++)
      if (k + j < 16) s += pw[j] * pa[k + j];
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wi <= 0; ai <= 0; skc <= 0; dcnt <= 0;
      pe_done <= 1'b0;
      pe_psum_o <= '0;
    end else begin
      if (!busy) begin wi <= 0; ai <= 0; end
      if (pe_loadw && wi < 16) begin pw[wi] <= int'(pe_weights); wi <= wi + 1; end
      if (pe_loada && ai < 16) begin pa[ai] <= int'(pe_acts); ai <= ai + 1; end
      if (pe_start) dcnt <= 3;
      else if (dcnt != 0) dcnt <= dcnt - 1;
      pe_done <= (dcnt == 1) && !hold_low;
      pe_psum_o <= pe_sums ? PW'(pe_conv(skc)) : 20'hEEEEE;
      skc <= pe_sums ? skc + 1 : 0;
    end
  end

  task automatic do_cfg(input int wc, input int ac);
    int t = 0;
    cfg_valid = 1'b1;
    cfg_wcount = CW'(wc);
    cfg_acount = CW'(ac);
    @(negedge clk);
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) fail("cfg_handshake");
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_stream(input bit is_act, input int n, input bit toggle);
    int i = 0;
    int t = 0;
    while (i < n && t < 100) begin
      logic v;
      v = !(toggle && t[0]);
      if (is_act) begin a_valid = v; a_data = DW'(a_vec[i]); end
      else        begin w_valid = v; w_data = DW'(w_vec[i]); end
      @(negedge clk);
      if (v && (is_act ? a_ready : w_ready)) begin
        if (is_act) exp_a.push_back(DW'(a_vec[i]));
        else        exp_w.push_back(DW'(w_vec[i]));
        i++;
      end
      @(posedge clk); #1;
      t++;
    end
    w_valid = 1'b0;
    a_valid = 1'b0;
    if (i < n) fail("stream_stalled");
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    @(negedge clk);
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (busy) fail("wait_idle_bound");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  int s_lw, s_la, s_st, s_su, s_out, s_eto, s_ecfg;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, pe_loadw, pe_loada, pe_start, pe_sums, out_valid, err_cfg,
        err_timeout, w_ready, a_ready, pe_weights, pe_acts, pe_wcount, pe_acount}, 0);
    chk("reset_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    @(posedge clk); #1;

    // cfg(3,16), continuous streams
    for (int i = 0; i < 16; i++) begin w_vec[i] = i + 1; a_vec[i] = i + 1; end
    psum_seed = PW'(100);
    for (int k = 0; k < 14; k++) exp_out.push_back(PW'(114 + 6 * k));
    s_lw = cnt_loadw; s_la = cnt_loada; s_st = cnt_start; s_su = cnt_sums; s_out = cnt_out;
    do_cfg(3, 16);
    send_stream(1'b0, 3, 1'b0);
    send_stream(1'b1, 16, 1'b0);
    wait_idle(200);
    chk("job1_loadw_cycles", cnt_loadw - s_lw, 3);
    chk("job1_loada_cycles", cnt_loada - s_la, 16);
    chk("job1_start_pulses", cnt_start - s_st, 1);
    chk("job1_sums_cycles", cnt_sums - s_su, 14);
    chk("job1_out_cycles", cnt_out - s_out, 14);
    chk("job1_pe_wcount", pe_wcount, 3);
    chk("job1_pe_acount", pe_acount, 16);

    // Toggling weight valid, cfg(3,4)
    w_vec[0] = 7; w_vec[1] = 8; w_vec[2] = 9;
    a_vec[0] = 10; a_vec[1] = 20; a_vec[2] = 30; a_vec[3] = 40;
    psum_seed = PW'(5);
    exp_out.push_back(PW'(505));
    exp_out.push_back(PW'(745));
    s_lw = cnt_loadw; s_su = cnt_sums;
    do_cfg(3, 4);
    send_stream(1'b0, 3, 1'b1);
    send_stream(1'b1, 4, 1'b0);
    wait_idle(200);
    chk("toggle_loadw_pulses", cnt_loadw - s_lw, 3);
    chk("toggle_sums_cycles", cnt_sums - s_su, 2);

    // Illegal configs
    s_lw = cnt_loadw; s_la = cnt_loada; s_ecfg = cnt_ecfg;
    exp_cfg_err++;
    do_cfg(0, 16);
    @(negedge clk);
    chk("cfg0_busy", busy, 0);
    @(posedge clk); #1;
    exp_cfg_err++;
    do_cfg(5, 4);
    @(negedge clk);
    chk("cfg54_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("cfg_err_pulses", cnt_ecfg - s_ecfg, 2);
    chk("cfg_err_no_strobes", (cnt_loadw - s_lw) + (cnt_loada - s_la), 0);
    @(posedge clk); #1;

    // Timeout: pe_done held low
    hold_low = 1'b1;
    w_vec[0] = 4; a_vec[0] = 6;
    s_su = cnt_sums; s_eto = cnt_eto;
    exp_to++;
    do_cfg(1, 1);
    send_stream(1'b0, 1, 1'b0);
    send_stream(1'b1, 1, 1'b0);
    wait_idle(100);
    chk("timeout_pulses", cnt_eto - s_eto, 1);
    chk("timeout_no_sums", cnt_sums - s_su, 0);
    hold_low = 1'b0;

    // Reset during LOADA
    for (int i = 0; i < 16; i++) begin w_vec[i] = i + 1; a_vec[i] = i + 1; end
    do_cfg(3, 16);
    send_stream(1'b0, 3, 1'b0);
    send_stream(1'b1, 2, 1'b0);
    a_valid = 1'b1;
    a_data = 8'd3;
    @(posedge clk); #1;
    chk("loada_before_rst", pe_loada, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_midjob_outputs", {busy, pe_loadw, pe_loada, pe_start, pe_sums, out_valid, err_cfg,
        err_timeout, w_ready, a_ready, pe_weights, pe_acts, pe_wcount, pe_acount}, 0);
    chk("rst_midjob_cfg_ready", cfg_ready, 1);
    a_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    s_lw = cnt_loadw; s_la = cnt_loada;
    w_valid = 1'b1;
    a_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_job_without_cfg_busy", busy, 0);
    end
    w_valid = 1'b0;
    a_valid = 1'b0;
    chk("no_job_without_cfg_strobes", (cnt_loadw - s_lw) + (cnt_loada - s_la), 0);
    @(posedge clk); #1;

    // cfg(3,3) after abort -> single sums cycle
    a_vec[0] = 4; a_vec[1] = 5; a_vec[2] = 6;
    psum_seed = '0;
    exp_out.push_back(PW'(32));
    s_su = cnt_sums; s_out = cnt_out;
    do_cfg(3, 3);
    send_stream(1'b0, 3, 1'b0);
    send_stream(1'b1, 3, 1'b0);
    wait_idle(200);
    chk("n1_sums_cycles", cnt_sums - s_su, 1);
    chk("n1_out_cycles", cnt_out - s_out, 1);

    chk("exp_w_drained", exp_w.size(), 0);
    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_out_drained", exp_out.size(), 0);
    chk("exp_err_drained", exp_cfg_err + exp_to, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
